// File: rtl/result_uart_pack_pkg.sv
// -----------------------------------------------------------------------------
// result_uart_pack_pkg
// Shared definitions for the result-to-UART framer: default header bytes,
// framer state encoding, byte-index width and the checksum step.
// -----------------------------------------------------------------------------
package result_uart_pack_pkg;

  localparam logic [7:0] HDR0_DEF = 8'hAA;
  localparam logic [7:0] HDR1_DEF = 8'h55;

  // Four bytes per 32-bit word, emitted most significant first.
  localparam int BIDX_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_LEN_H,
    S_LEN_L,
    S_DATA,
    S_CSUM
  } state_e;

  // 8-bit wrap-around checksum step.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/result_uart_pack_if.sv
// -----------------------------------------------------------------------------
// result_uart_pack_if
// Bundles the framer's upstream (calibration results, frame control), the
// uart_tx byte handshake and the status flags.
//   master : drives frame_start/data_len/valid_in/result_in and tx_done
//   slave  : the framer; drives tx_en/tx_data/busy/overflow
// -----------------------------------------------------------------------------
interface result_uart_pack_if;

  logic        frame_start;
  logic [15:0] data_len;
  logic        valid_in;
  logic [31:0] result_in;
  logic        tx_done;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        busy;
  logic        overflow;

  modport master (
    output frame_start, data_len, valid_in, result_in, tx_done,
    input  tx_en, tx_data, busy, overflow
  );

  modport slave (
    input  frame_start, data_len, valid_in, result_in, tx_done,
    output tx_en, tx_data, busy, overflow
  );

endinterface

// File: rtl/result_uart_pack_fifo.sv
// -----------------------------------------------------------------------------
// pack_fifo
// Synchronous FIFO buffering calibrated result words for the framer.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   flush_i    : empties the FIFO (takes priority over push/pop)
//   wr_en_i    : push din_i; refused while full_o
//   din_i      : word to push
//   rd_en_i    : pop; refused while empty_o
//   dout_o     : popped word, registered, valid the cycle after rd_en_i and
//                held until the next accepted pop
//   full_o     : no free entry
//   empty_o    : no stored entry
// -----------------------------------------------------------------------------
module pack_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] din_i,
  input  logic         rd_en_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] dout_q;
  logic         wr_ok, rd_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_ok   = wr_en_i & ~full_o;
  assign rd_ok   = rd_en_i & ~empty_o;
  assign dout_o  = dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage and read register hold data only; no reset needed.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    if (rd_ok) dout_q <= mem_q[rd_ptr_q[AW-1:0]];
  end

endmodule

// File: rtl/result_uart_pack.sv
// -----------------------------------------------------------------------------
// result_uart_pack
// Collects calibrated float words into a FIFO and serialises them to uart_tx as
//   0xAA 0x55 LEN_H LEN_L {word B3..B0}*LEN CSUM
// CSUM is the 8-bit wrap-around sum of LEN_H, LEN_L and all data bytes.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : frame_start/data_len, valid_in/result_in, tx_done in;
//                 tx_en/tx_data, busy, overflow out
// -----------------------------------------------------------------------------
module result_uart_pack
  import result_uart_pack_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] HDR0       = HDR0_DEF,
  parameter logic [7:0] HDR1       = HDR1_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  result_uart_pack_if.slave  bus
);

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         wcnt_q, wcnt_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic                fetch_q, fetch_d;
  logic                ld_q;
  logic [31:0]         shreg_q, shreg_d;
  logic [7:0]          csum_q, csum_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_en_q, tx_en_d;
  logic                ovf_q, ovf_d;

  logic                fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [31:0]         fifo_dout;
  logic                busy_w, done_ok, last_byte, last_word;

  pack_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (state_q == S_IDLE && bus.frame_start),
    .wr_en_i (fifo_wr),
    .din_i   (bus.result_in),
    .rd_en_i (fifo_rd),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign busy_w    = (state_q != S_IDLE);
  assign fifo_wr   = bus.valid_in & busy_w;
  // While a freshly popped word is being presented (ld_q) its byte has only
  // just been issued, so a tx_done then cannot belong to it.
  assign done_ok   = bus.tx_done & ~ld_q;
  assign last_byte = (bidx_q == BIDX_W'(3));
  assign last_word = (wcnt_q == len_q - 16'd1);

  // Pop as soon as a word is needed and available: straight out of LEN_L,
  // after the previous word's B0, or while stalled waiting for data.
  always_comb begin
    fifo_rd = 1'b0;
    if (!fifo_empty) begin
      if (state_q == S_LEN_L && done_ok && len_q != 16'd0) fifo_rd = 1'b1;
      if (state_q == S_DATA && !ld_q) begin
        if (fetch_q)                                  fifo_rd = 1'b1;
        else if (done_ok && last_byte && !last_word)  fifo_rd = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.frame_start) state_d = S_HDR0;
      S_HDR0:  if (done_ok) state_d = S_HDR1;
      S_HDR1:  if (done_ok) state_d = S_LEN_H;
      S_LEN_H: if (done_ok) state_d = S_LEN_L;
      S_LEN_L: if (done_ok) state_d = (len_q == 16'd0) ? S_CSUM : S_DATA;
      S_DATA:  if (done_ok && !fetch_q && last_byte && last_word) state_d = S_CSUM;
      S_CSUM:  if (done_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    tx_en_d   = fifo_rd;   // a pop always issues that word's B3 next cycle
    tx_data_d = tx_data_q;
    csum_d    = csum_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    bidx_d    = bidx_q;
    fetch_d   = fetch_q;
    shreg_d   = shreg_q;
    ovf_d     = ovf_q | (fifo_wr & fifo_full);

    unique case (state_q)
      S_IDLE: begin
        if (bus.frame_start) begin
          len_d     = bus.data_len;
          ovf_d     = 1'b0;
          csum_d    = 8'h00;
          wcnt_d    = 16'd0;
          bidx_d    = '0;
          fetch_d   = 1'b0;
          tx_en_d   = 1'b1;
          tx_data_d = HDR0;
        end
      end
      S_HDR0: begin
        if (done_ok) begin
          tx_en_d   = 1'b1;
          tx_data_d = HDR1;
        end
      end
      S_HDR1: begin
        if (done_ok) begin
          tx_en_d   = 1'b1;
          tx_data_d = len_q[15:8];
          csum_d    = csum_add(csum_q, len_q[15:8]);
        end
      end
      S_LEN_H: begin
        if (done_ok) begin
          tx_en_d   = 1'b1;
          tx_data_d = len_q[7:0];
          csum_d    = csum_add(csum_q, len_q[7:0]);
        end
      end
      S_LEN_L: begin
        if (done_ok) begin
          if (len_q == 16'd0) begin
            tx_en_d   = 1'b1;
            tx_data_d = csum_q;
          end else begin
            wcnt_d  = 16'd0;
            bidx_d  = '0;
            fetch_d = fifo_empty;
          end
        end
      end
      S_DATA: begin
        if (ld_q) begin
          // B3 goes out straight from the FIFO register this cycle; capture
          // it and keep the remaining three bytes in the shift register.
          tx_data_d = fifo_dout[31:24];
          shreg_d   = {fifo_dout[23:0], 8'h00};
          csum_d    = csum_add(csum_q, fifo_dout[31:24]);
        end else if (fetch_q) begin
          if (!fifo_empty) fetch_d = 1'b0;
        end else if (done_ok) begin
          if (!last_byte) begin
            bidx_d    = bidx_q + BIDX_W'(1);
            tx_en_d   = 1'b1;
            tx_data_d = shreg_q[31:24];
            shreg_d   = {shreg_q[23:0], 8'h00};
            csum_d    = csum_add(csum_q, shreg_q[31:24]);
          end else if (last_word) begin
            tx_en_d   = 1'b1;
            tx_data_d = csum_q;
          end else begin
            wcnt_d  = wcnt_q + 16'd1;
            bidx_d  = '0;
            fetch_d = fifo_empty;
          end
        end
      end
      S_CSUM: ;
      default: ;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      ovf_q     <= 1'b0;
      wcnt_q    <= 16'd0;
      bidx_q    <= '0;
      fetch_q   <= 1'b0;
      ld_q      <= 1'b0;
    end else begin
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      ovf_q     <= ovf_d;
      wcnt_q    <= wcnt_d;
      bidx_q    <= bidx_d;
      fetch_q   <= fetch_d;
      ld_q      <= fifo_rd;
    end
  end

  // Data registers: always (re)initialised by frame_start or a pop before use.
  always_ff @(posedge clk) begin
    len_q   <= len_d;
    csum_q  <= csum_d;
    shreg_q <= shreg_d;
  end

  assign bus.tx_en    = tx_en_q;
  assign bus.tx_data  = ld_q ? fifo_dout[31:24] : tx_data_q;
  assign bus.busy     = busy_w;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_result_uart_pack.sv
module tb_result_uart_pack;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  result_uart_pack_if bus();

  result_uart_pack #(.FIFO_DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          n_rx        = 0;
  int          tx_delay    = 10;
  int          pend        = 0;
  bit          uart_on     = 1'b0;
  logic [7:0]  last_tx     = 8'h00;
  logic [7:0]  exp_q[$];
  logic [31:0] mw[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference frame: header, length, words MSB first, optional checksum.
  function automatic logic [7:0] model_frame(input logic [15:0] len, input int nw, input bit with_csum);
    logic [7:0]  s;
    logic [31:0] w;
    s = len[15:8] + len[7:0];
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(len[15:8]);
    exp_q.push_back(len[7:0]);
    for (int i = 0; i < nw; i++) begin
      w = mw[i];
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(w[8*b +: 8]);
        s = s + w[8*b +: 8];
      end
    end
    if (with_csum) exp_q.push_back(s);
    return s;
  endfunction

  // uart_tx stand-in: tx_done pulses tx_delay cycles after each tx_en.
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_done = 1'b0;
      if (!uart_on) pend = 0;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) bus.tx_done = 1'b1;
      end else if (bus.tx_en) pend = tx_delay;
    end
  end

  // Every issued byte is checked against the reference stream.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.tx_en) begin
          n_rx++;
          last_tx = bus.tx_data;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_tx_en: got byte 0x%0h, expected no byte at %0t", bus.tx_data, $time);
          end else begin
            check("tx_byte", {24'h0, bus.tx_data}, {24'h0, exp_q.pop_front()});
          end
        end
        if (bus.tx_done) check("tx_data_hold", {24'h0, bus.tx_data}, {24'h0, last_tx});
      end
    end
  end

  task automatic start_frame(input logic [15:0] len);
    @(negedge clk);
    bus.frame_start = 1'b1;
    bus.data_len    = len;
    @(negedge clk);
    bus.frame_start = 1'b0;
    check("busy_after_start", {31'h0, bus.busy}, 32'h1);
    check("hdr0_tx_en", {31'h0, bus.tx_en}, 32'h1);
  endtask

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.valid_in  = 1'b1;
      bus.result_in = mw[first + i];
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int bound);
    int k = 0;
    while (n_rx < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    check("rx_count_reached", (n_rx >= n) ? 32'h1 : 32'h0, 32'h1);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (bus.busy && k < bound) begin
      @(negedge clk);
      k++;
    end
    check("busy_drop", {31'h0, bus.busy}, 32'h0);
    check("bytes_outstanding", exp_q.size(), 32'h0);
  endtask

  initial begin
    int         base;
    logic [7:0] cs;
    bus.frame_start = 1'b0;
    bus.data_len    = 16'h0;
    bus.valid_in    = 1'b0;
    bus.result_in   = 32'h0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_en",    {31'h0, bus.tx_en},    32'h0);
    check("rst_tx_data",  {24'h0, bus.tx_data},  32'h0);
    check("rst_busy",     {31'h0, bus.busy},     32'h0);
    check("rst_overflow", {31'h0, bus.overflow}, 32'h0);
    rst_n = 1'b1;
    uart_on = 1'b1;
    tx_delay = 3;

    // Reset while waiting on LEN_H abandons the frame
    mw.delete();
    cs = model_frame(16'd3, 0, 1'b0);
    base = n_rx;
    start_frame(16'd3);
    wait_rx(base + 3, 200);
    @(negedge clk);
    rst_n = 1'b0;
    uart_on = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_tx_en", {31'h0, bus.tx_en}, 32'h0);
    check("abort_busy",  {31'h0, bus.busy},  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    uart_on = 1'b1;
    repeat (30) @(negedge clk);
    check("no_tx_after_abort", n_rx, base + 3);

    // valid_in while idle is ignored; len=0 frame is AA 55 00 00 00
    mw.delete();
    mw.push_back(32'h11111111);
    mw.push_back(32'h22222222);
    push_words(0, 2);
    mw.delete();
    cs = model_frame(16'd0, 0, 1'b1);
    check("model_len0_csum", {24'h0, cs}, 32'h0);
    base = n_rx;
    start_frame(16'd0);
    wait_idle(300);
    check("len0_byte_count", n_rx - base, 32'd5);

    // Two words: 00+02 + 3F+80+00+00 + C0+49+0F+DB = 0x2B4 -> 0xB4
    tx_delay = 10;
    mw.delete();
    mw.push_back(32'h3F800000);
    mw.push_back(32'hC0490FDB);
    cs = model_frame(16'd2, 2, 1'b1);
    check("model_len2_csum", {24'h0, cs}, 32'hB4);
    base = n_rx;
    start_frame(16'd2);
    push_words(0, 2);
    wait_idle(400);
    check("len2_byte_count", n_rx - base, 32'd13);
    check("len2_last_byte", {24'h0, last_tx}, 32'hB4);

    // Empty FIFO in DATA: no bytes until the word arrives, then B3 promptly.
    // 00+01 + DE+AD+BE+EF = 0x339 -> 0x39
    mw.delete();
    mw.push_back(32'hDEADBEEF);
    cs = model_frame(16'd1, 1, 1'b1);
    check("model_len1_csum", {24'h0, cs}, 32'h39);
    base = n_rx;
    start_frame(16'd1);
    wait_rx(base + 4, 200);
    repeat (60) @(negedge clk);
    check("stall_gap", n_rx, base + 4);
    @(negedge clk);
    bus.valid_in  = 1'b1;
    bus.result_in = 32'hDEADBEEF;
    @(negedge clk);
    bus.valid_in = 1'b0;
    check("late_no_early_tx", {31'h0, bus.tx_en}, 32'h0);
    @(negedge clk);
    check("late_b3_tx_en", {31'h0, bus.tx_en}, 32'h1);
    check("late_b3_data", {24'h0, bus.tx_data}, 32'hDE);
    wait_idle(300);

    // frame_start mid-frame is ignored
    mw.delete();
    mw.push_back(32'h12345678);
    mw.push_back(32'h9ABCDEF0);
    cs = model_frame(16'd2, 2, 1'b1);
    base = n_rx;
    start_frame(16'd2);
    push_words(0, 2);
    wait_rx(base + 2, 200);
    @(negedge clk);
    bus.frame_start = 1'b1;
    bus.data_len    = 16'd7;
    @(negedge clk);
    bus.frame_start = 1'b0;
    wait_idle(400);
    check("midstart_byte_count", n_rx - base, 32'd13);
    check("midstart_overflow", {31'h0, bus.overflow}, 32'h0);

    // Overflow: 20-word burst into a 16-deep FIFO, last 4 dropped
    tx_delay = 40;
    mw.delete();
    for (int i = 0; i < 16; i++) mw.push_back(32'hA0000000 + i * 32'h01010101);
    for (int i = 16; i < 20; i++) mw.push_back(32'h5A5A0000 + i);
    cs = model_frame(16'd20, 20, 1'b1);
    base = n_rx;
    start_frame(16'd20);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.valid_in  = 1'b1;
      bus.result_in = (i < 16) ? mw[i] : (32'hEEEE0000 + i);
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    check("overflow_set", {31'h0, bus.overflow}, 32'h1);
    wait_rx(base + 68, 6000);
    repeat (200) @(negedge clk);
    check("stall_after_16", n_rx, base + 68);
    check("stall_busy", {31'h0, bus.busy}, 32'h1);
    push_words(16, 4);
    wait_idle(2000);
    check("ovf_byte_count", n_rx - base, 32'd85);
    check("overflow_sticky", {31'h0, bus.overflow}, 32'h1);

    // Next frame_start clears overflow
    tx_delay = 2;
    mw.delete();
    cs = model_frame(16'd0, 0, 1'b1);
    start_frame(16'd0);
    check("overflow_cleared", {31'h0, bus.overflow}, 32'h0);
    wait_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
